// File: rtl/vga_framebuf_if.sv
// vga_framebuf_if
//   Game-side bus of the VGA framebuffer: single-pixel write handshake
//   (wr_req/wr_ack) plus the full-buffer clear request and its busy flag.
//   The master modport is the game logic, the slave modport is the framebuffer.
interface vga_framebuf_if;
  logic        wr_req;
  logic [7:0]  wr_x;
  logic [6:0]  wr_y;
  logic [11:0] wr_color;
  logic        wr_ack;
  logic        clr_req;
  logic [11:0] clr_color;
  logic        busy;

  modport master (
    output wr_req, wr_x, wr_y, wr_color, clr_req, clr_color,
    input  wr_ack, busy
  );

  modport slave (
    input  wr_req, wr_x, wr_y, wr_color, clr_req, clr_color,
    output wr_ack, busy
  );
endinterface

// File: rtl/vga_framebuf.sv
// vga_framebuf
//   Pixel source for the VGA timing controller. Holds a down-scaled 12-bit
//   RGB framebuffer ({B,G,R}, 4 bits each) of FB_W x FB_H logical pixels,
//   each replicated 2^SCALE_SH times in both directions on screen.
//   - Display port: one pixel per vga_clk, registered, 1-cycle latency,
//     read-first against a same-address write, never stalled.
//   - Game port (vga_framebuf_if.slave): req/ack pixel writes and a clear
//     engine that fills the whole buffer with one colour.
//   Optional feature macro: FB_OOB_FLAG_EN adds a sticky oob_err output that
//   flags acknowledged out-of-range writes (cleared by rst or a new clear).
module vga_framebuf #(
  parameter int SCALE_SH = 2,
  parameter int FB_W     = 160,
  parameter int FB_H     = 120
) (
  input  logic        vga_clk,
  input  logic        rst,
  input  logic [9:0]  row_addr,
  input  logic [9:0]  col_addr,
  input  logic        rdn,
  output logic [11:0] d_out,
  vga_framebuf_if.slave fb_bus
`ifdef FB_OOB_FLAG_EN
  ,
  output logic        oob_err
`endif
);

  localparam int DEPTH = FB_W * FB_H;
  localparam int AW    = $clog2(DEPTH);

  // Visible display area in physical pixels; anything at or above is blank.
  localparam logic [9:0] ROW_LIM = 10'(FB_H << SCALE_SH);
  localparam logic [9:0] COL_LIM = 10'(FB_W << SCALE_SH);

  // Logical write coordinate limits.
  localparam logic [7:0] X_LIM = 8'(FB_W);
  localparam logic [6:0] Y_LIM = 7'(FB_H);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } fb_state_e;

  // Framebuffer storage; contents are deliberately not reset.
  logic [11:0] mem_r [DEPTH];

  // Display-side address path
  logic [9:0]    row_sh_s;
  logic [9:0]    col_sh_s;
  logic [AW-1:0] rd_addr_s;
  logic          rd_ok_s;

  // Game-side write path
  logic [AW-1:0] wr_addr_s;
  logic          wr_in_range_s;

  // FSM state and its next-state values
  fb_state_e     state_r, state_nx;
  logic [AW-1:0] cnt_r, cnt_nx;
  logic [11:0]   fill_r, fill_nx;
  logic          busy_r, busy_nx;
  logic          ack_r, ack_nx;

  // RAM write port, shared by pixel writes and the clear engine
  logic          we_s;
  logic [AW-1:0] wa_s;
  logic [11:0]   wd_s;

`ifdef FB_OOB_FLAG_EN
  logic          oob_r, oob_nx;
`endif

  // Map the physical display position to a linear logical address. The
  // address is only used when the position is inside the visible area, so
  // the wider intermediate products for wrapped inputs never reach the RAM.
  always_comb begin
    row_sh_s  = row_addr >> SCALE_SH;
    col_sh_s  = col_addr >> SCALE_SH;
    rd_addr_s = AW'(32'(row_sh_s) * FB_W + 32'(col_sh_s));
    rd_ok_s   = (!rdn) && (row_addr < ROW_LIM) && (col_addr < COL_LIM);
  end

  // Linear address and range check of the requested game write.
  always_comb begin
    wr_addr_s     = AW'(32'(fb_bus.wr_y) * FB_W + 32'(fb_bus.wr_x));
    wr_in_range_s = (fb_bus.wr_x < X_LIM) && (fb_bus.wr_y < Y_LIM);
  end

  // Next-state and write-port logic of the IDLE/CLEAR controller.
  always_comb begin
    state_nx = state_r;
    cnt_nx   = cnt_r;
    fill_nx  = fill_r;
    busy_nx  = busy_r;
    ack_nx   = 1'b0;
    we_s     = 1'b0;
    wa_s     = {AW{1'b0}};
    wd_s     = 12'h000;
`ifdef FB_OOB_FLAG_EN
    oob_nx   = oob_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (fb_bus.clr_req) begin
          // Clear has priority; a pending write waits until the fill ends.
          state_nx = ST_CLEAR;
          cnt_nx   = {AW{1'b0}};
          fill_nx  = fb_bus.clr_color;
          busy_nx  = 1'b1;
`ifdef FB_OOB_FLAG_EN
          oob_nx   = 1'b0;
`endif
        end else if (fb_bus.wr_req && !ack_r) begin
          // The ack of the previous cycle blocks service, so a held request
          // is served every second cycle and acks never touch.
          ack_nx = 1'b1;
          if (wr_in_range_s) begin
            we_s = 1'b1;
            wa_s = wr_addr_s;
            wd_s = fb_bus.wr_color;
          end else begin
`ifdef FB_OOB_FLAG_EN
            oob_nx = 1'b1;
`else
            we_s   = 1'b0;
`endif
          end
        end else begin
          ack_nx = 1'b0;
        end
      end
      ST_CLEAR: begin
        we_s = 1'b1;
        wa_s = cnt_r;
        wd_s = fill_r;
        if (cnt_r == LAST_ADDR) begin
          state_nx = ST_IDLE;
          cnt_nx   = {AW{1'b0}};
          busy_nx  = 1'b0;
        end else begin
          cnt_nx   = cnt_r + ADDR_ONE;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = {AW{1'b0}};
        busy_nx  = 1'b0;
      end
    endcase
  end

  // Controller state register with synchronous reset.
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= {AW{1'b0}};
      fill_r  <= 12'h000;
      busy_r  <= 1'b0;
      ack_r   <= 1'b0;
    end else begin
      state_r <= state_nx;
      cnt_r   <= cnt_nx;
      fill_r  <= fill_nx;
      busy_r  <= busy_nx;
      ack_r   <= ack_nx;
    end
  end

`ifdef FB_OOB_FLAG_EN
  // Sticky out-of-range write flag.
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      oob_r <= 1'b0;
    end else begin
      oob_r <= oob_nx;
    end
  end

  assign oob_err = oob_r;
`endif

  // RAM write port; suppressed while reset is asserted so a reset in the
  // middle of a clear leaves exactly the pixels filled before it.
  always_ff @(posedge vga_clk) begin
    if (we_s && !rst) begin
      mem_r[wa_s] <= wd_s;
    end
  end

  // Registered display output; reads the pre-write RAM value (read-first)
  // and blanks disabled or off-screen positions.
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      d_out <= 12'h000;
    end else if (rd_ok_s) begin
      d_out <= mem_r[rd_addr_s];
    end else begin
      d_out <= 12'h000;
    end
  end

  assign fb_bus.wr_ack = ack_r;
  assign fb_bus.busy   = busy_r;

endmodule

// File: tb/tb_vga_framebuf.sv
// tb_vga_framebuf
//   Self-checking bench for vga_framebuf. Display reads go through a
//   scoreboard queue: the expected pixel (from a bench-side model of the
//   logical framebuffer) is pushed when the address is driven and popped
//   when the registered d_out appears one cycle later.
module tb_vga_framebuf;
  localparam int FB_W  = 160;
  localparam int FB_H  = 120;
  localparam int DEPTH = FB_W * FB_H;

  logic        vga_clk;
  logic        rst;
  logic [9:0]  row_addr;
  logic [9:0]  col_addr;
  logic        rdn;
  logic [11:0] d_out;
`ifdef FB_OOB_FLAG_EN
  logic        oob_err;
`endif

  vga_framebuf_if bus ();

  vga_framebuf #(.SCALE_SH(2), .FB_W(FB_W), .FB_H(FB_H)) dut (
    .vga_clk  (vga_clk),
    .rst      (rst),
    .row_addr (row_addr),
    .col_addr (col_addr),
    .rdn      (rdn),
    .d_out    (d_out),
    .fb_bus   (bus)
`ifdef FB_OOB_FLAG_EN
    ,
    .oob_err  (oob_err)
`endif
  );

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [11:0] model [DEPTH];
  logic [11:0] exp_q [$];
  logic        drv_v  = 1'b0;
  logic        mon_v  = 1'b0;
  logic [11:0] exp_px;

  initial begin
    vga_clk = 1'b0;
    forever #20 vga_clk = ~vga_clk;
  end

  initial begin
    #(40 * 150000);
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Read pipeline tracking: the address driven before edge n shows on d_out after it.
  always @(posedge vga_clk) mon_v <= drv_v;

  // Scoreboard compare of every display read.
  always @(negedge vga_clk) begin
    if (mon_v) begin
      if (exp_q.size() == 0) begin
        check_eq("rd_queue_empty", 32'd1, 32'd0);
      end else begin
        exp_px = exp_q.pop_front();
        check_eq("d_out", {20'd0, d_out}, {20'd0, exp_px});
      end
    end
  end

  task automatic rd_px(input int row, input int col, input logic rd_n, input logic [11:0] exp);
    @(negedge vga_clk);
    row_addr = 10'(row);
    col_addr = 10'(col);
    rdn      = rd_n;
    drv_v    = 1'b1;
    exp_q.push_back(exp);
  endtask

  task automatic rd_logical(input int x, input int y);
    rd_px(y * 4 + int'($urandom_range(0, 3)), x * 4 + int'($urandom_range(0, 3)),
          1'b0, model[y * FB_W + x]);
  endtask

  task automatic rd_idle();
    @(negedge vga_clk);
    drv_v = 1'b0;
    rdn   = 1'b1;
    @(negedge vga_clk);
    @(negedge vga_clk);
    check_eq("rd_queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wr_px(input int x, input int y, input logic [11:0] c);
    logic got;
    @(negedge vga_clk);
    bus.wr_x     = 8'(x);
    bus.wr_y     = 7'(y);
    bus.wr_color = c;
    bus.wr_req   = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge vga_clk);
      if (bus.wr_ack) got = 1'b1;
    end
    bus.wr_req = 1'b0;
    check_eq("wr_ack_seen", {31'd0, got}, 32'd1);
    @(negedge vga_clk);
    check_eq("wr_ack_single", {31'd0, bus.wr_ack}, 32'd0);
    if (got && x < FB_W && y < FB_H) model[y * FB_W + x] = c;
  endtask

  // Start a clear (optionally with a simultaneous write request) and measure busy.
  task automatic do_clear(input logic [11:0] c, input logic with_wr);
    int busy_n;
    int acks;
    @(negedge vga_clk);
    bus.clr_req   = 1'b1;
    bus.clr_color = c;
    if (with_wr) bus.wr_req = 1'b1;
    @(negedge vga_clk);
    bus.clr_req = 1'b0;
    check_eq("busy_rise", {31'd0, bus.busy}, 32'd1);
    check_eq("no_ack_at_clear_start", {31'd0, bus.wr_ack}, 32'd0);
    busy_n = 1;
    acks   = 0;
    for (int i = 0; i < 20100; i++) begin
      @(negedge vga_clk);
      if (bus.wr_ack) acks++;
      if (!bus.busy) break;
      busy_n++;
    end
    check_eq("busy_cycles", 32'(busy_n), 32'd19200);
    check_eq("ack_during_clear", 32'(acks), 32'd0);
    for (int i = 0; i < DEPTH; i++) model[i] = c;
  endtask

  initial begin
    int          acks;
    logic        got;
    rst           = 1'b1;
    row_addr      = 10'd0;
    col_addr      = 10'd0;
    rdn           = 1'b1;
    bus.wr_req    = 1'b0;
    bus.wr_x      = 8'd0;
    bus.wr_y      = 7'd0;
    bus.wr_color  = 12'h000;
    bus.clr_req   = 1'b0;
    bus.clr_color = 12'h000;
    repeat (3) @(negedge vga_clk);
    check_eq("rst_d_out", {20'd0, d_out}, 32'd0);
    check_eq("rst_wr_ack", {31'd0, bus.wr_ack}, 32'd0);
    check_eq("rst_busy", {31'd0, bus.busy}, 32'd0);
`ifdef FB_OOB_FLAG_EN
    check_eq("rst_oob", {31'd0, oob_err}, 32'd0);
`endif
    rst = 1'b0;

    // Single write, then the whole 4x4 replicated block reads back.
    wr_px(5, 3, 12'hF0A);
    for (int r = 12; r <= 15; r++)
      for (int c = 20; c <= 23; c++)
        rd_px(r, c, 1'b0, 12'hF0A);
    rd_idle();

    // Held request: acks on every second cycle only.
    @(negedge vga_clk);
    bus.wr_x = 8'd7; bus.wr_y = 7'd3; bus.wr_color = 12'h0B1; bus.wr_req = 1'b1;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge vga_clk);
      if (bus.wr_ack) acks++;
    end
    bus.wr_req = 1'b0;
    check_eq("held_req_acks", 32'(acks), 32'd4);
    model[3 * FB_W + 7] = 12'h0B1;
    @(negedge vga_clk);
    rd_px(13, 29, 1'b0, 12'h0B1);

    // Disabled / off-screen reads blank the output.
    rd_px(13, 21, 1'b1, 12'h000);
    rd_px(1023, 21, 1'b0, 12'h000);
    rd_px(13, 1023, 1'b0, 12'h000);
    rd_px(13, 21, 1'b0, 12'hF0A);
    rd_idle();

    // Full clear, then every logical pixel and the screen edges.
    do_clear(12'h123, 1'b0);
    for (int y = 0; y < FB_H; y++)
      for (int x = 0; x < FB_W; x++)
        rd_logical(x, y);
    rd_px(479, 639, 1'b0, 12'h123);
    rd_px(480, 0, 1'b0, 12'h000);
    rd_px(0, 640, 1'b0, 12'h000);
    rd_idle();

    // Out-of-range writes are acked but leave the RAM alone.
    wr_px(160, 0, 12'hFFF);
`ifdef FB_OOB_FLAG_EN
    check_eq("oob_set", {31'd0, oob_err}, 32'd1);
`endif
    wr_px(0, 120, 12'hEEE);
    wr_px(1, 1, 12'h321);
`ifdef FB_OOB_FLAG_EN
    check_eq("oob_sticky", {31'd0, oob_err}, 32'd1);
`endif
    rd_logical(0, 1);
    rd_logical(1, 1);
    rd_logical(159, 0);
    rd_logical(159, 119);
    rd_idle();

    // Read-during-write at the same address returns the old value.
    @(negedge vga_clk);
    bus.wr_x = 8'd2; bus.wr_y = 7'd2; bus.wr_color = 12'h9C3; bus.wr_req = 1'b1;
    row_addr = 10'd8; col_addr = 10'd8; rdn = 1'b0; drv_v = 1'b1;
    exp_q.push_back(12'h123);
    @(negedge vga_clk);
    bus.wr_req = 1'b0;
    check_eq("rdw_ack", {31'd0, bus.wr_ack}, 32'd1);
    exp_q.push_back(12'h9C3);
    model[2 * FB_W + 2] = 12'h9C3;
    rd_idle();

    // Clear and write requested together: clear first, write afterwards.
    bus.wr_x = 8'd10; bus.wr_y = 7'd20; bus.wr_color = 12'hABC;
    do_clear(12'h456, 1'b1);
`ifdef FB_OOB_FLAG_EN
    check_eq("oob_cleared", {31'd0, oob_err}, 32'd0);
`endif
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge vga_clk);
      if (bus.wr_ack) got = 1'b1;
    end
    bus.wr_req = 1'b0;
    check_eq("ack_after_clear", {31'd0, got}, 32'd1);
    model[20 * FB_W + 10] = 12'hABC;
    rd_logical(10, 20);
    rd_logical(11, 20);
    rd_logical(0, 0);
    rd_idle();

    // Reset in the middle of a clear: pixels 0..99 filled, rest untouched.
    @(negedge vga_clk);
    bus.clr_req = 1'b1; bus.clr_color = 12'h789;
    @(negedge vga_clk);
    bus.clr_req = 1'b0;
    repeat (100) @(negedge vga_clk);
    check_eq("busy_before_rst", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    @(negedge vga_clk);
    check_eq("busy_after_rst", {31'd0, bus.busy}, 32'd0);
    check_eq("d_out_after_rst", {20'd0, d_out}, 32'd0);
    rst = 1'b0;
    for (int p = 0; p < 100; p++) model[p] = 12'h789;
    for (int p = 0; p < 102; p++) rd_logical(p % FB_W, p / FB_W);
    rd_idle();
    wr_px(3, 0, 12'h5A5);
    rd_logical(3, 0);
    rd_logical(4, 0);
    rd_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
